// File: rtl/timer_slave_pkg.sv
// timer_slave_pkg: register offsets and CTRL bit indices shared by the timer; TIMER_PWM_EN is left undefined by default
package timer_slave_pkg;
  localparam int TMR_CTRL   = 0;
  localparam int TMR_PRESC  = 1;
  localparam int TMR_RELOAD = 2;
  localparam int TMR_COUNT  = 3;
  localparam int TMR_STATUS = 4;
  localparam int TMR_CMP    = 5;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by p+1 while enabled and emits a one-cycle tick
module timer_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] p,
  output logic         tick
);
  logic [W-1:0] pcnt;
  assign tick = en & (pcnt == p);
  // wrap at the terminal value, restart on enable, hold while disabled
  always_ff @(posedge clk) begin
    if (rst || clr) pcnt <= '0;
    else if (tick) pcnt <= '0;
    else if (en) pcnt <= pcnt + W'(1);
  end
endmodule

// File: rtl/timer_slave.sv
// timer_slave: memory-mapped down-counting timer with level interrupt; optional PWM output under TIMER_PWM_EN
module timer_slave
  import timer_slave_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              int_timer
`ifdef TIMER_PWM_EN
  ,
  output logic              pwm_out
`endif
);
  logic [2:0] ctrl, ctrl_n;
  logic [DATA_W-1:0] presc, reload, count, count_n;
  logic pend, pend_n, tick, uf, wr;
  logic w_ctrl, w_presc, w_reload, w_count, w_status;
  assign wr       = sel & we;
  assign w_ctrl   = wr && off == OFF_W'(TMR_CTRL);
  assign w_presc  = wr && off == OFF_W'(TMR_PRESC);
  assign w_reload = wr && off == OFF_W'(TMR_RELOAD);
  assign w_count  = wr && off == OFF_W'(TMR_COUNT);
  assign w_status = wr && off == OFF_W'(TMR_STATUS);
  assign uf       = tick & (count == '0);

  timer_prescaler #(.W(DATA_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl[CTRL_EN]),
    .clr  (w_ctrl & wd[CTRL_EN] & ~ctrl[CTRL_EN]),
    .p    (presc),
    .tick (tick)
  );

  // next state: software writes beat hardware updates, except underflow beats the PEND clear
  always_comb begin
    ctrl_n  = w_ctrl ? wd[2:0] : (uf & ~ctrl[CTRL_AUTO]) ? ctrl & ~3'(1 << CTRL_EN) : ctrl;
    count_n = w_count ? wd : uf ? (ctrl[CTRL_AUTO] ? reload : '0) : tick ? count - DATA_W'(1) : count;
    pend_n  = uf | (pend & ~(w_status & wd[0]));
  end

  // register file; interrupt is registered from next-state so it rises with PEND
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl      <= '0;
      presc     <= '0;
      reload    <= '0;
      count     <= '0;
      pend      <= 1'b0;
      int_timer <= 1'b0;
    end else begin
      ctrl      <= ctrl_n;
      count     <= count_n;
      pend      <= pend_n;
      int_timer <= pend_n & ctrl_n[CTRL_IE];
      if (w_presc) presc <= wd;
      if (w_reload) reload <= wd;
    end
  end

`ifdef TIMER_PWM_EN
  logic [DATA_W-1:0] cmp;
  // compare register and registered PWM, one clock behind COUNT
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp     <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (wr && off == OFF_W'(TMR_CMP)) cmp <= wd;
      pwm_out <= ctrl[CTRL_EN] & (count < cmp);
    end
  end
`endif

  // combinational read mux, zero when not a selected read
  always_comb begin
    rd = '0;
    if (sel && !we)
      case (off)
        OFF_W'(TMR_CTRL):   rd = DATA_W'(ctrl);
        OFF_W'(TMR_PRESC):  rd = presc;
        OFF_W'(TMR_RELOAD): rd = reload;
        OFF_W'(TMR_COUNT):  rd = count;
        OFF_W'(TMR_STATUS): rd = DATA_W'(pend);
`ifdef TIMER_PWM_EN
        OFF_W'(TMR_CMP):    rd = cmp;
`endif
        default:            rd = '0;
      endcase
  end
endmodule

// File: doc/timer_slave.md
# timer_slave

Memory-mapped down-counting timer that answers CPU data-bus accesses as a bus target and drives the `int_timer` interrupt line into the CPU interrupt vector. The CPU issues the accesses; this block only responds and raises the interrupt. It sits behind the address decoder in `BUS`, which routes `mem_addr`, `mem_ctrl` and the write data to it and muxes its read data back onto the shared data bus.

## Interface
Parameters:
- `DATA_W`, 16: bus data width and counter width.
- `OFF_W`, 3: register-offset width, taken from the low address bits.

Ports (clock and reset first):
- `clk` in 1: system clock. One clock only.
- `rst` in 1: reset, synchronous and active-high.
- `sel` in 1: decoded chip select from `BUS`, high when the address falls in this block's window.
- `we` in 1: write strobe, the bus `ctrl`. High = write, low = read.
- `off` in `OFF_W`: register offset.
- `wd` in `DATA_W`: write data.
- `rd` out `DATA_W`: read data.
- `int_timer` out 1: level interrupt to the CPU.
- `pwm_out` out 1: exists only with `TIMER_PWM_EN`.

## Operation
Register map (word offsets):
- 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable). Other bits read 0.
- 1 PRESC: prescaler terminal value P. A tick occurs every P+1 clocks.
- 2 RELOAD: reload value R.
- 3 COUNT: current counter. A write loads the counter directly.
- 4 STATUS: bit0 PEND. Writing 1 clears it; writing 0 has no effect.
- 5 CMP: PWM compare value. Exists only with `TIMER_PWM_EN`.
- 6, 7: read 0; writes are ignored.

Prescaler:
- `pcnt` increments while EN=1.
- When `pcnt == P`, a tick occurs and `pcnt` returns to 0.
- A write that changes EN from 0 to 1 clears `pcnt`.
- While EN=0, `pcnt` holds.

Counter, on each tick:
- If COUNT≠0, then COUNT−1.
- If COUNT=0 (underflow):
  - PEND is set.
  - If AUTO=1, COUNT is loaded with R.
  - If AUTO=0, COUNT stays 0 and EN is cleared by hardware.

Interrupt:
- `int_timer` = PEND & IE, formed from flops only with no other logic in the path.

Simultaneous events, required behaviour:
- Software write to COUNT and a tick in the same cycle: the write wins and no decrement occurs.
- STATUS write-1-clear and an underflow in the same cycle: the set wins, so PEND stays 1.
- Software write to CTRL and a hardware EN clear in the same cycle: the software value wins.
- P=0: a tick occurs every clock.
- R=0 with AUTO=1: underflow every tick.

## Timing
- Reset values: all registers 0, `pcnt`=0, `rd`=0 when unselected, `int_timer`=0, `pwm_out`=0.
- Reads are combinational. `rd` reflects the register at `off` in the same cycle that `sel`=1 and `we`=0. `rd`=0 otherwise.
- Writes take effect at the clock edge where `sel`=1 and `we`=1. The new value is visible to a read in the next cycle.
- Underflow latency:
  - With COUNT=N loaded and EN=1, the first tick occurs P+1 clocks after enable.
  - PEND is set at the edge of tick N+1, i.e. (N+1)·(P+1) clocks after enable.
  - `int_timer` rises in the same cycle that PEND becomes 1.
- Reset asserted mid-count: all state returns to reset values at the next edge, and no pending interrupt survives.

## Configuration
- `TIMER_PWM_EN` defined:
  - CMP register present at offset 5.
  - `pwm_out` = EN & (COUNT < CMP), registered, so it lags COUNT by one clock.
  - With CMP=0, `pwm_out` stays 0. With CMP > R, `pwm_out` stays 1 while EN=1.
- `TIMER_PWM_EN` undefined:
  - Offset 5 reads 0 and writes to it are ignored.
  - No `pwm_out` port and no compare logic.

## Structure
- The shared defines header holds:
  - register offsets (`TMR_CTRL`..`TMR_CMP`);
  - CTRL bit indices;
  - the `TIMER_PWM_EN` default.
- One sub-module, `timer_prescaler`:
  - inputs: `clk`, `rst`, EN, clear, P;
  - output: a single-cycle `tick`.
- The register file, counter and interrupt logic live in `timer_slave`.

## Test plan
- Reset → every offset reads 0, `int_timer`=0.
- Write P=3, R=4, COUNT=2, CTRL=0b111 → PEND and `int_timer` set 12 clocks after the CTRL write. COUNT then reads 4, and the next underflow comes 20 clocks later.
- AUTO=0, P=0, COUNT=1, EN=1 → underflow after 2 clocks. CTRL then reads 0b100 (EN cleared) and COUNT holds at 0.
- STATUS write 1 in the same cycle as an underflow → PEND stays 1. A later write of 1 with no underflow clears it, and `int_timer` drops the next cycle.
- COUNT write of 7 in a tick cycle → COUNT reads 7 next cycle, with no decrement applied.
- With `TIMER_PWM_EN`: P=0, R=9, CMP=3 → `pwm_out` high for 3 of every 10 clocks. Offset 5 reads 3.
